// File: rtl/mem_tile_responder_if.sv
// Tile memory bus between a cache tile (master) and the tile memory responder (slave).
// Carries the request fields and the registered response code and data.
interface mem_tile_responder_if;
    logic [31:0]  memInAddr;
    logic [127:0] memInData;
    logic         memInOE;
    logic         memInWR;
    logic [4:0]   memInOp;
    logic [127:0] memOutData;
    logic [1:0]   memOutOK;

    modport master (
        output memInAddr,
        output memInData,
        output memInOE,
        output memInWR,
        output memInOp,
        input  memOutData,
        input  memOutOK
    );

    modport slave (
        input  memInAddr,
        input  memInData,
        input  memInOE,
        input  memInWR,
        input  memInOp,
        output memOutData,
        output memOutOK
    );
endinterface

// File: rtl/mem_tile_responder.sv
// Tile memory bus target: latches a request, holds for LATENCY cycles, then answers OK/FAULT.
// Optional macro MEM_TILE_RESPONDER_POSTWR_EN posts non-faulting stores with a one-cycle OK.
module mem_tile_responder #(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_tile_responder_if.slave  bus
);

    localparam int         TILES    = 1 << ADDR_BITS;
    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    localparam logic [1:0] OK_READY = 2'd0;
    localparam logic [1:0] OK_OK    = 2'd1;
    localparam logic [1:0] OK_HOLD  = 2'd2;
    localparam logic [1:0] OK_FAULT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Out-of-range address, unknown op, or a simultaneous load and store.
    function automatic logic req_fault(input logic [31:0] addr, input logic [4:0] op,
                                       input logic oe, input logic wr);
        logic hi_bits;
        logic bad_op;
        hi_bits = ((addr >> (ADDR_BITS + 4)) != 32'd0);
        bad_op  = (op != 5'd1) && (op != 5'd2);
        return hi_bits || bad_op || (oe && wr);
    endfunction

    function automatic logic [31:0] lane_sel(input logic [127:0] tile, input logic [1:0] lane);
        logic [31:0] dw;
        case (lane)
            2'd0:    dw = tile[31:0];
            2'd1:    dw = tile[63:32];
            2'd2:    dw = tile[95:64];
            2'd3:    dw = tile[127:96];
            default: dw = 32'd0;
        endcase
        return dw;
    endfunction

    function automatic logic [127:0] lane_merge(input logic [127:0] tile, input logic [31:0] dw,
                                                input logic [1:0] lane);
        logic [127:0] res;
        res = tile;
        case (lane)
            2'd0:    res[31:0]   = dw;
            2'd1:    res[63:32]  = dw;
            2'd2:    res[95:64]  = dw;
            2'd3:    res[127:96] = dw;
            default: res = tile;
        endcase
        return res;
    endfunction

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   tile_q, tile_d;
    logic [1:0]             lane_q, lane_d;
    logic [127:0]           data_q, data_d;
    logic                   oe_q, oe_d;
    logic                   wr_q, wr_d;
    logic                   tile_op_q, tile_op_d;
    logic                   fault_q, fault_d;
    logic [1:0]             ok_q, ok_d;
    logic [127:0]           out_data_q, out_data_d;

    logic [127:0]           ram_q [TILES];

    logic                   req_s;
    logic                   req_fault_s;
    logic [127:0]           rd_tile_s;
    logic [127:0]           ram_wdata_s;
    logic                   ram_we_s;

    assign req_s       = bus.memInOE || bus.memInWR;
    assign req_fault_s = req_fault(bus.memInAddr, bus.memInOp, bus.memInOE, bus.memInWR);
    assign rd_tile_s   = ram_q[tile_q];
    assign ram_wdata_s = tile_op_q ? data_q : lane_merge(rd_tile_s, data_q[31:0], lane_q);

    assign bus.memOutOK   = ok_q;
    assign bus.memOutData = out_data_q;

    // Next-state, latch and response computation for the request FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tile_d     = tile_q;
        lane_d     = lane_q;
        data_d     = data_q;
        oe_d       = oe_q;
        wr_d       = wr_q;
        tile_op_d  = tile_op_q;
        fault_d    = fault_q;
        ok_d       = OK_READY;
        out_data_d = 128'd0;
        ram_we_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    tile_d    = bus.memInAddr[ADDR_BITS+3:4];
                    lane_d    = bus.memInAddr[3:2];
                    data_d    = bus.memInData;
                    oe_d      = bus.memInOE;
                    wr_d      = bus.memInWR;
                    tile_op_d = (bus.memInOp == 5'd1);
                    fault_d   = req_fault_s;
                    cnt_d     = LAT_INIT;
`ifdef MEM_TILE_RESPONDER_POSTWR_EN
                    // Posted store: acknowledge now, commit on the edge leaving RESP.
                    if (bus.memInWR && !req_fault_s) begin
                        state_d = ST_RESP;
                        ok_d    = OK_OK;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_BUSY;
                        ok_d    = OK_HOLD;
                    end
`else
                    state_d = ST_BUSY;
                    ok_d    = OK_HOLD;
`endif
                end else begin
                    state_d = ST_IDLE;
                    ok_d    = OK_READY;
                end
            end
            ST_BUSY: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                    if (fault_q) begin
                        ok_d = OK_FAULT;
                    end else if (oe_q) begin
                        ok_d       = OK_OK;
                        out_data_d = tile_op_q ? rd_tile_s : {96'd0, lane_sel(rd_tile_s, lane_q)};
                    end else begin
                        ok_d     = OK_OK;
                        ram_we_s = wr_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    ok_d  = OK_HOLD;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ok_d    = OK_READY;
`ifdef MEM_TILE_RESPONDER_POSTWR_EN
                ram_we_s = wr_q && !fault_q;
`else
                ram_we_s = 1'b0;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM state, latched request and registered response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            tile_q     <= '0;
            lane_q     <= 2'd0;
            data_q     <= 128'd0;
            oe_q       <= 1'b0;
            wr_q       <= 1'b0;
            tile_op_q  <= 1'b0;
            fault_q    <= 1'b0;
            ok_q       <= OK_READY;
            out_data_q <= 128'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tile_q     <= tile_d;
            lane_q     <= lane_d;
            data_q     <= data_d;
            oe_q       <= oe_d;
            wr_q       <= wr_d;
            tile_op_q  <= tile_op_d;
            fault_q    <= fault_d;
            ok_q       <= ok_d;
            out_data_q <= out_data_d;
        end
    end

    // RAM write port; contents survive reset but a write on a reset edge is dropped.
    always_ff @(posedge clock) begin
        if (ram_we_s && !reset) begin
            ram_q[tile_q] <= ram_wdata_s;
        end
    end

endmodule

// File: tb/tb_mem_tile_responder.sv
// Randomized self-checking bench for mem_tile_responder against a tile-array reference model.
module tb_mem_tile_responder;

    localparam int         LAT      = 2;
    localparam logic [1:0] R_READY  = 2'd0;
    localparam logic [1:0] R_OK     = 2'd1;
    localparam logic [1:0] R_HOLD   = 2'd2;
    localparam logic [1:0] R_FAULT  = 2'd3;

    logic clock;
    logic reset;
    int   tests_run;
    int   tests_failed;

    logic [127:0] model_mem [int];

    mem_tile_responder_if bus();

    mem_tile_responder #(.ADDR_BITS(12), .LATENCY(LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one request at the current negedge and check it against the model.
    task automatic run_txn(input string tag, input logic [4:0] op, input logic [31:0] addr,
                           input logic [127:0] wdata, input logic oe, input logic wr,
                           input int exp_ready);
        logic         fault;
        logic [1:0]   exp_ok;
        logic [127:0] exp_data;
        int           exp_hold;
        int           t;
        logic [127:0] tile;
        logic [1:0]   ok;
        logic [127:0] rd;
        int           n_ready;
        int           n_hold;
        logic         dirty;
        logic         done;

        fault    = (addr[31:16] != 16'd0) || !(op == 5'd1 || op == 5'd2) || (oe && wr);
        t        = int'(addr[15:4]);
        exp_ok   = fault ? R_FAULT : R_OK;
        exp_data = 128'd0;
        exp_hold = LAT;
        if (!fault && oe) begin
            tile = model_mem[t];
            if (op == 5'd1) exp_data = tile;
            else            exp_data = {96'd0, tile[addr[3:2]*32 +: 32]};
        end
        if (!fault && wr) begin
`ifdef MEM_TILE_RESPONDER_POSTWR_EN
            exp_hold = 0;
`endif
            if (op == 5'd1) begin
                model_mem[t] = wdata;
            end else begin
                tile = model_mem.exists(t) ? model_mem[t] : 128'd0;
                tile[addr[3:2]*32 +: 32] = wdata[31:0];
                model_mem[t] = tile;
            end
        end

        bus.memInAddr = addr;
        bus.memInData = wdata;
        bus.memInOp   = op;
        bus.memInOE   = oe;
        bus.memInWR   = wr;
        n_ready = 0;
        n_hold  = 0;
        dirty   = 1'b0;
        done    = 1'b0;
        ok      = R_READY;
        rd      = 128'd0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (bus.memOutOK == R_HOLD) begin
                n_hold++;
                dirty = dirty | (bus.memOutData != 128'd0);
            end else if (bus.memOutOK == R_READY) begin
                n_ready++;
                dirty = dirty | (bus.memOutData != 128'd0);
            end else begin
                ok   = bus.memOutOK;
                rd   = bus.memOutData;
                done = 1'b1;
                break;
            end
        end
        if (!done) check_val({tag, ":timeout"}, 128'd0, 128'd1);
        check_val({tag, ":ok"},    128'(ok), 128'(exp_ok));
        check_val({tag, ":data"},  rd, exp_data);
        check_val({tag, ":hold"},  128'(n_hold), 128'(exp_hold));
        check_val({tag, ":ready"}, 128'(n_ready), 128'(exp_ready));
        check_val({tag, ":quiet"}, 128'(dirty), 128'd0);
    endtask

    task automatic go_idle(input int n);
        bus.memInOE = 1'b0;
        bus.memInWR = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check_val("idle:ok", 128'(bus.memOutOK), 128'(R_READY));
            check_val("idle:data", bus.memOutData, 128'd0);
        end
    endtask

    initial begin
        logic [127:0] rnd;
        logic [31:0]  addr;
        logic [4:0]   op;
        logic         oe;
        logic         wr;
        int           gap;
        int           r;

        tests_run     = 0;
        tests_failed  = 0;
        reset         = 1'b1;
        bus.memInAddr = 32'd0;
        bus.memInData = 128'd0;
        bus.memInOE   = 1'b0;
        bus.memInWR   = 1'b0;
        bus.memInOp   = 5'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_val("rst:ok", 128'(bus.memOutOK), 128'(R_READY));
            check_val("rst:data", bus.memOutData, 128'd0);
        end

        run_txn("tst", 5'd1, 32'h120, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, 1'b1, 0);
        run_txn("tld", 5'd1, 32'h120, 128'd0, 1'b1, 1'b0, 1);
        go_idle(1);

        run_txn("dst", 5'd2, 32'h128, {96'd0, 32'hDEADBEEF}, 1'b0, 1'b1, 0);
        run_txn("dld", 5'd1, 32'h120, 128'd0, 1'b1, 1'b0, 1);
        check_val("dld:const", model_mem[18], 128'h00112233_DEADBEEF_8899AABB_CCDDEEFF);
        go_idle(1);

        run_txn("bst", 5'd1, 32'h130, 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3, 1'b0, 1'b1, 0);
        go_idle(1);
        for (int k = 0; k < 4; k++) begin
            run_txn("burst", 5'd2, 32'h130 + 32'(4 * k), 128'd0, 1'b1, 1'b0, (k == 0) ? 0 : 1);
        end
        go_idle(2);

        run_txn("f_range", 5'd2, 32'h0010_0000, 128'd0, 1'b1, 1'b0, 0);
        run_txn("f_op",    5'd3, 32'h0, 128'd0, 1'b1, 1'b0, 1);
        run_txn("f_st",    5'd3, 32'h120, 128'hFFFF, 1'b0, 1'b1, 1);
        run_txn("f_both",  5'd1, 32'h120, 128'hFFFF, 1'b1, 1'b1, 1);
        run_txn("f_chk",   5'd1, 32'h120, 128'd0, 1'b1, 1'b0, 1);
        go_idle(1);

`ifndef MEM_TILE_RESPONDER_POSTWR_EN
        run_txn("r_old", 5'd1, 32'h200, 128'h0BAD_F00D_0000_1111_2222_3333_4444_5555, 1'b0, 1'b1, 0);
        go_idle(1);
        bus.memInAddr = 32'h200;
        bus.memInData = 128'h1234;
        bus.memInOp   = 5'd1;
        bus.memInWR   = 1'b1;
        @(negedge clock);
        check_val("r_hold1", 128'(bus.memOutOK), 128'(R_HOLD));
        @(negedge clock);
        check_val("r_hold2", 128'(bus.memOutOK), 128'(R_HOLD));
        reset       = 1'b1;
        bus.memInWR = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check_val("r_ready", 128'(bus.memOutOK), 128'(R_READY));
        check_val("r_data", bus.memOutData, 128'd0);
        run_txn("r_load", 5'd1, 32'h200, 128'd0, 1'b1, 1'b0, 0);
        go_idle(1);
`endif

        for (int t = 16; t < 32; t++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            run_txn("init", 5'd1, 32'(t) << 4, rnd, 1'b0, 1'b1, (t == 16) ? 0 : 1);
        end
        gap = 1;
        for (int n = 0; n < 200; n++) begin
            rnd  = {$urandom, $urandom, $urandom, $urandom};
            addr = (32'($urandom_range(16, 31)) << 4) | 32'($urandom_range(0, 15));
            r    = $urandom_range(0, 9);
            op   = (r == 0) ? 5'(3 + $urandom_range(0, 28)) : 5'($urandom_range(1, 2));
            if ($urandom_range(0, 9) == 0) addr = addr | (32'($urandom_range(1, 65535)) << 16);
            r  = $urandom_range(0, 9);
            oe = (r < 5);
            wr = (r == 0) || (r >= 5);
            run_txn("rand", op, addr, rnd, oe, wr, gap);
            if ($urandom_range(0, 1) == 0) begin
                gap = 1;
            end else begin
                go_idle($urandom_range(1, 3));
                gap = 0;
            end
        end
        go_idle(1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
